// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Holds the arbiter state encoding, parameter defaults and the saturating count helper.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned COUNT_W       = 16;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == COUNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from last_owner+1 with wrap.
// Purely combinational; valid is low when no request is set.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    valid    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    // k runs 1..NUM_REQ so last_owner itself is considered last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last_owner) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ writers into one FIFO write port.
// One IDLE cycle separates bursts; fifo_full stalls a burst without losing beats.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      fifo_write_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [COUNT_W-1:0]        write_count
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [COUNT_W-1:0] count_q;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req       (req),
    .last_owner(last_q),
    .valid     (pick_valid),
    .index     (pick_idx)
  );

  assign owner_req   = req[owner_q];
  assign write_count = count_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    beat_d        = beat_q;
    last_d        = last_q;
    grant         = '0;
    ack           = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        grant[owner_q] = 1'b1;
        fifo_data_in   = req_data[32'(owner_q)*DATA_W +: DATA_W];
        fifo_write_en  = owner_req & ~fifo_full;
        ack[owner_q]   = owner_req & ~fifo_full;
        // A dropped request ends the burst even while the FIFO is full.
        if (fifo_write_en) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end else if (!owner_req) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
      last_q  <= LAST_INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      if (fifo_write_en) count_q <= sat_inc(count_q);
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter, plus a saturation run on a long-burst instance.
module tb_fifo_write_arbiter;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic [3:0]  grant;
    logic        we;
    logic [7:0]  dout;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic [15:0] write_count;

  logic        rst2_n;
  logic [1:0]  req2;
  logic [15:0] req_data2;
  logic [1:0]  ack2;
  logic [1:0]  grant2;
  logic        full2;
  logic        we2;
  logic [7:0]  data2;
  logic [15:0] write_count2;

  vec_t       vecs[$];
  logic [7:0] dat[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
    .grant(grant), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_data_in(fifo_data_in), .write_count(write_count)
  );

  fifo_write_arbiter #(.NUM_REQ(2), .DATA_W(8), .BURST_LEN(16)) dut2 (
    .clk(clk), .reset_n(rst2_n), .req(req2), .req_data(req_data2), .ack(ack2),
    .grant(grant2), .fifo_full(full2), .fifo_write_en(we2),
    .fifo_data_in(data2), .write_count(write_count2)
  );

  function automatic void add(input logic rst, input logic [3:0] rq, input logic fl,
                              input logic [3:0] gr, input logic we, input logic [7:0] d,
                              input int cnt);
    vec_t v;
    v.rst = rst; v.req = rq; v.full = fl;
    v.grant = gr; v.we = we; v.dout = d; v.cnt = 16'(cnt);
    vecs.push_back(v);
  endfunction

  function automatic logic [3:0] oh(input int o);
    return 4'b0001 << o;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ack;
    int model, viol, extra;
    reset_n = 1'b0; req = '0; fifo_full = 1'b0; req_data = 32'hDDCCBBAA;
    rst2_n = 1'b0; req2 = '0; full2 = 1'b0; req_data2 = 16'h5A3C;

    // single requester: 4-beat burst, idle, 2 more beats
    add(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0001, 0, 4'b0000, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++) add(1, 4'b0001, 0, 4'b0001, 1, 8'hAA, k);
    add(1, 4'b0001, 0, 4'b0000, 0, 8'h00, 4);
    add(1, 4'b0001, 0, 4'b0001, 1, 8'hAA, 4);
    add(1, 4'b0001, 0, 4'b0001, 1, 8'hAA, 5);
    add(1, 4'b0000, 0, 4'b0001, 0, 8'hAA, 6);
    add(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 6);
    // all requesting: owners 0,1,2,3,0 with one idle between bursts
    add(0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0);
    for (int b = 0; b < 5; b++) begin
      add(1, 4'b1111, 0, 4'b0000, 0, 8'h00, 4*b);
      for (int k = 0; k < 4; k++) add(1, 4'b1111, 0, oh(b % 4), 1, dat[b % 4], 4*b + k);
    end
    add(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 20);
    // owner 2 stalled by fifo_full for 3 cycles after beat 2
    add(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0100, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0100, 0, 4'b0100, 1, 8'hCC, 0);
    add(1, 4'b0100, 0, 4'b0100, 1, 8'hCC, 1);
    for (int k = 0; k < 3; k++) add(1, 4'b0100, 1, 4'b0100, 0, 8'hCC, 2);
    add(1, 4'b0100, 0, 4'b0100, 1, 8'hCC, 2);
    add(1, 4'b0100, 0, 4'b0100, 1, 8'hCC, 3);
    add(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 4);
    // req[1] drops after 2 beats, pending req[3] granted after one idle
    add(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1010, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1010, 0, 4'b0010, 1, 8'hBB, 0);
    add(1, 4'b1010, 0, 4'b0010, 1, 8'hBB, 1);
    add(1, 4'b1000, 0, 4'b0010, 0, 8'hBB, 2);
    add(1, 4'b1000, 0, 4'b0000, 0, 8'h00, 2);
    add(1, 4'b1000, 0, 4'b1000, 1, 8'hDD, 2);
    add(1, 4'b0000, 0, 4'b1000, 0, 8'hDD, 3);
    add(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 3);
    // reset mid-burst at beat 2, then requester 3 alone
    add(1, 4'b0001, 0, 4'b0000, 0, 8'h00, 3);
    add(1, 4'b0001, 0, 4'b0001, 1, 8'hAA, 3);
    add(1, 4'b0001, 0, 4'b0001, 1, 8'hAA, 4);
    add(0, 4'b0001, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1000, 0, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1000, 0, 4'b1000, 1, 8'hDD, 0);
    add(1, 4'b0000, 0, 4'b1000, 0, 8'hDD, 1);
    add(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset_n = vecs[i].rst; req = vecs[i].req; fifo_full = vecs[i].full;
      @(negedge clk);
      exp_ack = vecs[i].we ? vecs[i].grant : 4'b0000;
      n_vec++;
      if (grant !== vecs[i].grant || ack !== exp_ack || fifo_write_en !== vecs[i].we ||
          fifo_data_in !== vecs[i].dout || write_count !== vecs[i].cnt) begin
        n_err++;
        $display("FAIL vec%0d: got grant=%b ack=%b we=%b data=%h cnt=%h, want grant=%b ack=%b we=%b data=%h cnt=%h",
                 i, grant, ack, fifo_write_en, fifo_data_in, write_count,
                 vecs[i].grant, exp_ack, vecs[i].we, vecs[i].dout, vecs[i].cnt);
      end
    end

    // asynchronous reset between clock edges
    @(posedge clk); #1; reset_n = 1'b1; req = 4'b0001; fifo_full = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (fifo_write_en !== 1'b1 || grant !== 4'b0001) begin
      n_err++;
      $display("FAIL pre_async_reset: got we=%b grant=%b, want we=1 grant=0001", fifo_write_en, grant);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (fifo_write_en !== 1'b0 || grant !== 4'b0000 || ack !== 4'b0000 ||
        fifo_data_in !== 8'h00 || write_count !== 16'h0000) begin
      n_err++;
      $display("FAIL async_reset: got we=%b grant=%b ack=%b data=%h cnt=%h, want all zero",
               fifo_write_en, grant, ack, fifo_data_in, write_count);
    end

    // saturation: drive dut2 up to 0xFFFE writes, then 3 more
    @(posedge clk); #1; rst2_n = 1'b1; req2 = 2'b11;
    model = 0; viol = 0;
    for (int c = 0; c < 80000 && model < 65534; c++) begin
      full2 = (c < 400) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (we2) begin
        model++;
        if (full2) viol++;
        if (ack2 !== grant2) viol++;
        if (data2 !== (grant2[1] ? 8'h5A : 8'h3C)) viol++;
      end
      @(posedge clk); #1;
    end
    full2 = 1'b0;
    n_vec++;
    if (model != 65534 || write_count2 !== 16'hFFFE) begin
      n_err++;
      $display("FAIL preload: got cnt=%h after %0d writes, want cnt=fffe after 65534 writes", write_count2, model);
    end
    n_vec++;
    if (viol != 0) begin
      n_err++;
      $display("FAIL write_rules: got %0d bad write cycles, want 0", viol);
    end
    extra = 0;
    for (int c = 0; c < 40 && extra < 3; c++) begin
      @(negedge clk);
      if (we2) extra++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (extra != 3 || write_count2 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL saturate: got cnt=%h after %0d extra writes, want cnt=ffff after 3", write_count2, extra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
